dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single-port data RAM between two masters:
//    - M0: core load/store unit.
//    - M1: DMA/loader port that preloads data memory and inspects it.
//  Sits between core_top/loader and the RAM macro, inside soc_top.
//  Carries one transaction at a time. Arbitration is round-robin or fixed-priority.
//  Checks every address against the data-memory window; a miss returns an error and never touches the RAM.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  byte address of data RAM word 0
//  DEPTH      2048           RAM depth in 32-bit words (power of 2)
//  AW         11             RAM word-address width, = log2(DEPTH)
//  RD_LAT     1              RAM read latency in cycles (1..4)
//  FIXED_PRI  0              0 = round-robin; 1 = M0 always wins ties
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  mN_req     in   1   request (N = 0,1); held with its fields until mN_gnt
//  mN_we      in   1   1 = write, 0 = read
//  mN_sel     in   4   byte enables
//  mN_addr    in   32  byte address; [1:0] ignored
//  mN_wdata   in   32  write data
//  mN_gnt     out  1   one-cycle pulse: command accepted (or rejected, see mN_err)
//  mN_rvalid  out  1   one-cycle pulse: mN_rdata valid
//  mN_rdata   out  32  read data; holds its value until the next read for that master
//  mN_err     out  1   one-cycle pulse with mN_gnt: address outside the window
//  ram_ce     out  1   RAM chip enable
//  ram_we     out  1   RAM write enable
//  ram_sel    out  4   RAM byte enables
//  ram_addr   out  AW  RAM word address = (addr - BASE_ADDR) >> 2
//  ram_wdata  out  32  RAM write data
//  ram_rdata  in   32  RAM read data; valid RD_LAT cycles after the ce cycle
// BEHAVIOUR
//  Outputs are registered. Reset values: all ram_* = 0; all mN_* outputs = 0; state = IDLE; last = 1.
//  FSM states:
//   IDLE
//    - If any mN_req: pick winner W, latch its fields, go to CMD.
//    - No requests: stay in IDLE.
//   CMD (1 cycle)
//    - In range: ram_ce = 1 and ram_* driven from the latched fields; mW_gnt = 1.
//    - Out of range (addr < BASE or addr >= BASE + 4*DEPTH): ram_ce = 0, mW_gnt = 1, mW_err = 1.
//    - Next state: in-range read -> RWAIT; write or error -> IDLE.
//   RWAIT (RD_LAT cycles, down-counter)
//    - On the last cycle, capture ram_rdata into mW_rdata; go to RESP.
//   RESP (1 cycle)
//    - mW_rvalid = 1; go to IDLE.
//  Latency: from req sampled in IDLE,
//   - write: gnt in the next cycle;
//   - read: rvalid 3 + RD_LAT - 1 cycles after sampling (RD_LAT = 1 -> 3).
//  Throughput: one write per 2 cycles; one read per 3 + RD_LAT cycles.
//  Arbitration happens only in IDLE:
//   - Both requesting with FIXED_PRI = 0: grant the master != last; set last = W.
//   - Single requester always wins; last is still updated.
//   - FIXED_PRI = 1: M0 wins whenever M0 requests.
//  Requests that arrive or change while not in IDLE are ignored until the next IDLE.
//  Losing master: sees no gnt and keeps its request asserted.
//  Dropped request (req falls before gnt): not a legal master action; the arbiter does not check for it.
//  ram_ce is never high outside CMD; at most one mN_gnt per cycle; gnt and rvalid are mutually exclusive.
//  Address wrap: the word index uses bits [AW+1:2] of (addr - BASE); the range check runs first, so no aliasing.
//  Reset during RWAIT/RESP: the read is dropped, no rvalid pulse, and the next request is arbitrated from IDLE.
// TESTING
//  1. M0 writes 0xDEADBEEF at 0x8000_0004 (sel = F)
//     -> next cycle: ram_ce = 1, ram_we = 1, ram_addr = 1, m0_gnt = 1.
//     Then M0 reads 0x8000_0004 -> m0_rvalid 3 cycles after req, m0_rdata = 0xDEADBEEF.
//  2. M0 and M1 both hold read requests for 4 transactions
//     -> grant order M0, M1, M0, M1; with FIXED_PRI = 1 -> M0, M0, M0, M0.
//  3. M1 reads 0x7FFF_FFFC and 0x8000_2000 -> m1_gnt = 1 and m1_err = 1 each time;
//     ram_ce stays 0; no rvalid.
//  4. Read of the last word 0x8000_1FFC -> ram_addr = 2047, valid data returned;
//     repeat with RD_LAT = 3 -> rvalid 5 cycles after req.
//  5. rst pulsed on the RWAIT cycle of an M0 read -> no m0_rvalid;
//     all outputs 0 the cycle after rst; a new M1 request is serviced normally.
//  6. M1 requests while M0's read is in RWAIT -> M1 granted only after RESP;
//     m0_rdata is not corrupted.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-master arbiter for the single-port data RAM: one transaction at a time,
// round-robin or fixed priority, with a data-memory window check on every address.
module dram_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 2048,
    parameter int          AW        = 11,
    parameter int          RD_LAT    = 1,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_sel,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_sel,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [3:0]    ram_sel,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;
    localparam int          CW        = 3;

    typedef enum logic [1:0] {IDLE, CMD, RWAIT, RESP} state_t;

    state_t        state;
    logic          last;
    logic          cur;
    logic          cur_rd;
    logic [CW-1:0] lat_cnt;

    logic          pick;
    logic          sel_we;
    logic [3:0]    sel_sel;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [31:0]   offset;
    logic          in_range;

    // Winner selection and window check on the live request fields (used only in IDLE).
    always_comb begin
        if (m0_req && m1_req)
            pick = FIXED_PRI ? 1'b0 : ~last;
        else
            pick = ~m0_req;
        sel_we    = pick ? m1_we    : m0_we;
        sel_sel   = pick ? m1_sel   : m0_sel;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        offset    = sel_addr - BASE_ADDR;
        in_range  = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    end

    // Outputs are loaded on the edge entering a state so they are visible during it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cur       <= 1'b0;
            cur_rd    <= 1'b0;
            lat_cnt   <= '0;
            m0_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_gnt    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        cur       <= pick;
                        last      <= pick;
                        cur_rd    <= in_range && !sel_we;
                        ram_ce    <= in_range;
                        ram_we    <= in_range && sel_we;
                        ram_sel   <= sel_sel;
                        ram_addr  <= offset[AW+1:2];
                        ram_wdata <= sel_wdata;
                        m0_gnt    <= !pick;
                        m1_gnt    <= pick;
                        m0_err    <= !pick && !in_range;
                        m1_err    <= pick && !in_range;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    lat_cnt <= CW'(RD_LAT - 1);
                    state   <= cur_rd ? RWAIT : IDLE;
                end
                RWAIT: begin
                    if (lat_cnt == '0) begin
                        if (cur) begin
                            m1_rdata  <= ram_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= ram_rdata;
                            m0_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: default, fixed-priority and RD_LAT=3 instances
// share master stimulus; each instance has its own behavioural RAM.
module tb_dram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_ram_ce, fp_ram_we;
    logic [3:0]  fp_ram_sel;
    logic [10:0] fp_ram_addr;
    logic [31:0] fp_ram_wdata, fp_ram_rdata;

    logic        l3_m0_gnt, l3_m0_rvalid, l3_m0_err, l3_m1_gnt, l3_m1_rvalid, l3_m1_err;
    logic [31:0] l3_m0_rdata, l3_m1_rdata;
    logic        l3_ram_ce, l3_ram_we;
    logic [3:0]  l3_ram_sel;
    logic [10:0] l3_ram_addr;
    logic [31:0] l3_ram_wdata, l3_ram_rdata;

    int checks = 0;
    int failures = 0;

    dram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    dram_arbiter #(.FIXED_PRI(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
        .ram_ce(fp_ram_ce), .ram_we(fp_ram_we), .ram_sel(fp_ram_sel), .ram_addr(fp_ram_addr),
        .ram_wdata(fp_ram_wdata), .ram_rdata(fp_ram_rdata)
    );

    dram_arbiter #(.RD_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(l3_m0_gnt), .m0_rvalid(l3_m0_rvalid), .m0_rdata(l3_m0_rdata), .m0_err(l3_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(l3_m1_gnt), .m1_rvalid(l3_m1_rvalid), .m1_rdata(l3_m1_rdata), .m1_err(l3_m1_err),
        .ram_ce(l3_ram_ce), .ram_we(l3_ram_we), .ram_sel(l3_ram_sel), .ram_addr(l3_ram_addr),
        .ram_wdata(l3_ram_wdata), .ram_rdata(l3_ram_rdata)
    );

    // Behavioural RAMs; a read without a proper ce returns a poison word.
    localparam logic [31:0] POISON = 32'h0BAD_0BAD;
    logic [31:0] mem_a [0:2047];
    logic [31:0] mem_f [0:2047];
    logic [31:0] mem_l [0:2047];
    logic [31:0] l3_p1, l3_p2;

    always @(posedge clk) begin
        if (ram_ce && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem_a[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= (ram_ce && !ram_we) ? mem_a[ram_addr] : POISON;
    end

    always @(posedge clk) begin
        if (fp_ram_ce && fp_ram_we)
            for (int b = 0; b < 4; b++)
                if (fp_ram_sel[b]) mem_f[fp_ram_addr][8*b +: 8] <= fp_ram_wdata[8*b +: 8];
        fp_ram_rdata <= (fp_ram_ce && !fp_ram_we) ? mem_f[fp_ram_addr] : POISON;
    end

    always @(posedge clk) begin
        if (l3_ram_ce && l3_ram_we)
            for (int b = 0; b < 4; b++)
                if (l3_ram_sel[b]) mem_l[l3_ram_addr][8*b +: 8] <= l3_ram_wdata[8*b +: 8];
        l3_p1        <= (l3_ram_ce && !l3_ram_we) ? mem_l[l3_ram_addr] : POISON;
        l3_p2        <= l3_p1;
        l3_ram_rdata <= l3_p2;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, ram_ce, ram_we} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rst_flags: got %b expected 00000000",
                     {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, ram_ce, ram_we});
        end
        checks++;
        if ({ram_sel, ram_addr, ram_wdata} !== 47'h0) begin
            failures++;
            $display("[TB] FAIL rst_ram: sel=%h addr=%h wdata=%h expected all 0", ram_sel, ram_addr, ram_wdata);
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL rst_rdata: m0=%h m1=%h expected 0", m0_rdata, m1_rdata);
        end
        rst = 1'b0;
        idle(2);
        checks++;
        if ({m0_gnt, m1_gnt, ram_ce} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL idle_quiet: gnt0/gnt1/ce=%b expected 000", {m0_gnt, m1_gnt, ram_ce});
        end
    endtask

    task automatic test_write_read();
        int rv;
        int pulses;
        m0_we = 1'b1; m0_sel = 4'hF; m0_addr = 32'h8000_0004; m0_wdata = 32'hDEAD_BEEF;
        m0_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_err, ram_ce, ram_we} !== 5'b10011) begin
            failures++;
            $display("[TB] FAIL wr_cmd: gnt0/gnt1/err0/ce/we=%b expected 10011",
                     {m0_gnt, m1_gnt, m0_err, ram_ce, ram_we});
        end
        checks++;
        if ({ram_addr, ram_sel, ram_wdata} !== {11'd1, 4'hF, 32'hDEAD_BEEF}) begin
            failures++;
            $display("[TB] FAIL wr_fields: addr=%0d sel=%h wdata=%h expected 1 f deadbeef",
                     ram_addr, ram_sel, ram_wdata);
        end
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, ram_ce} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL wr_after: gnt0/ce=%b expected 00", {m0_gnt, ram_ce});
        end
        m0_we = 1'b0;
        m0_req = 1'b1;
        rv = 0;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({m0_gnt, ram_ce, ram_we} !== 3'b110) begin
                    failures++;
                    $display("[TB] FAIL rd_cmd: gnt0/ce/we=%b expected 110", {m0_gnt, ram_ce, ram_we});
                end
                m0_req = 1'b0;
            end
            if (m0_rvalid === 1'b1) begin
                pulses++;
                if (rv == 0) rv = n;
            end
        end
        checks++;
        if (rv != 3 || pulses != 1) begin
            failures++;
            $display("[TB] FAIL rd_latency: rvalid cycle %0d pulses %0d expected 3 and 1", rv, pulses);
        end
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL rd_data: got %h expected deadbeef", m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ord_a, ord_f;
        int ka, kf;
        logic clash;
        do_reset();
        m0_we = 1'b0; m0_addr = 32'h8000_0004;
        m1_we = 1'b0; m1_addr = 32'h8000_0008; m1_sel = 4'hF;
        ord_a = '0; ord_f = '0; ka = 0; kf = 0; clash = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((m0_gnt || m1_gnt) && ka < 4) begin
                ord_a[ka] = m1_gnt;
                ka++;
            end
            if ((fp_m0_gnt || fp_m1_gnt) && kf < 4) begin
                ord_f[kf] = fp_m1_gnt;
                kf++;
            end
            if ((m0_gnt && m1_gnt) || ((m0_gnt || m1_gnt) && (m0_rvalid || m1_rvalid)))
                clash = 1'b1;
            if (ka == 4) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        checks++;
        if (ka != 4 || ord_a !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL rr_order: %0d grants order %b expected 4 grants 1010 (bit0 first, 1=M1)", ka, ord_a);
        end
        checks++;
        if (kf != 4 || ord_f !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL fp_order: %0d grants order %b expected 4 grants 0000", kf, ord_f);
        end
        checks++;
        if (clash !== 1'b0) begin
            failures++;
            $display("[TB] FAIL excl: got gnt/rvalid overlap %b expected 0", clash);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] bad [2];
        logic stray;
        bad[0] = 32'h7FFF_FFFC;
        bad[1] = 32'h8000_2000;
        idle(2);
        m1_we = 1'b0; m1_sel = 4'hF;
        for (int i = 0; i < 2; i++) begin
            m1_addr = bad[i];
            m1_req = 1'b1;
            stray = 1'b0;
            @(negedge clk);
            checks++;
            if ({m1_gnt, m1_err, m0_gnt, m0_err, ram_ce} !== 5'b11000) begin
                failures++;
                $display("[TB] FAIL oor_cmd %h: gnt1/err1/gnt0/err0/ce=%b expected 11000",
                         bad[i], {m1_gnt, m1_err, m0_gnt, m0_err, ram_ce});
            end
            m1_req = 1'b0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (m1_rvalid || m0_rvalid || ram_ce || m1_err) stray = 1'b1;
            end
            checks++;
            if (stray !== 1'b0) begin
                failures++;
                $display("[TB] FAIL oor_quiet %h: got activity %b expected 0", bad[i], stray);
            end
        end
    endtask

    task automatic test_last_word();
        int rv_a, rv_l;
        idle(6);
        m1_we = 1'b1; m1_sel = 4'hF; m1_addr = 32'h8000_1FFC; m1_wdata = 32'h1234_5678;
        m1_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({m1_gnt, m1_err, ram_ce, ram_we, ram_addr} !== {4'b1011, 11'd2047}) begin
            failures++;
            $display("[TB] FAIL last_wr: gnt1/err1/ce/we=%b addr=%0d expected 1011 2047",
                     {m1_gnt, m1_err, ram_ce, ram_we}, ram_addr);
        end
        m1_req = 1'b0;
        @(negedge clk);
        m0_we = 1'b0; m0_addr = 32'h8000_1FFC;
        m0_req = 1'b1;
        rv_a = 0;
        rv_l = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({m0_gnt, ram_ce, ram_addr} !== {2'b11, 11'd2047}) begin
                    failures++;
                    $display("[TB] FAIL last_rd_cmd: gnt0/ce=%b addr=%0d expected 11 2047",
                             {m0_gnt, ram_ce}, ram_addr);
                end
                m0_req = 1'b0;
            end
            if (m0_rvalid === 1'b1 && rv_a == 0) rv_a = n;
            if (l3_m0_rvalid === 1'b1 && rv_l == 0) rv_l = n;
        end
        checks++;
        if (rv_a != 3 || m0_rdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL last_rd: rvalid cycle %0d data %h expected 3 12345678", rv_a, m0_rdata);
        end
        checks++;
        if (rv_l != 5 || l3_m0_rdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL lat3_rd: rvalid cycle %0d data %h expected 5 12345678", rv_l, l3_m0_rdata);
        end
    endtask

    task automatic test_reset_in_rwait();
        int pulses;
        int rv;
        idle(6);
        m0_we = 1'b0; m0_addr = 32'h8000_0004;
        m0_req = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) m0_req = 1'b0;
            if (n == 2) rst = 1'b1;
            if (n == 3) begin
                rst = 1'b0;
                checks++;
                if ({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_ce, ram_we, m0_rdata} !== 38'h0) begin
                    failures++;
                    $display("[TB] FAIL rst_rwait_out: flags=%b m0_rdata=%h expected 0",
                             {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_ce, ram_we}, m0_rdata);
                end
            end
            if (n >= 2 && m0_rvalid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL rst_rwait_drop: got %0d rvalid pulses expected 0", pulses);
        end
        m1_we = 1'b0; m1_addr = 32'h8000_1FFC;
        m1_req = 1'b1;
        rv = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (m1_gnt !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rst_next_gnt: got %b expected 1", m1_gnt);
                end
                m1_req = 1'b0;
            end
            if (m1_rvalid === 1'b1 && rv == 0) rv = n;
        end
        checks++;
        if (rv != 3 || m1_rdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL rst_next_rd: rvalid cycle %0d data %h expected 3 12345678", rv, m1_rdata);
        end
    endtask

    task automatic test_busy_request();
        int rv0, g1, rv1;
        idle(6);
        m0_we = 1'b0; m0_addr = 32'h8000_0004;
        m1_we = 1'b0; m1_addr = 32'h8000_1FFC;
        m0_req = 1'b1;
        rv0 = 0; g1 = 0; rv1 = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) m0_req = 1'b0;
            if (m0_rvalid === 1'b1 && rv0 == 0) rv0 = n;
            if (m1_gnt === 1'b1 && g1 == 0) begin
                g1 = n;
                m1_req = 1'b0;
            end
            if (m1_rvalid === 1'b1 && rv1 == 0) rv1 = n;
            if (n == 2) m1_req = 1'b1;
        end
        checks++;
        if (rv0 != 3 || g1 != 5 || rv1 != 7) begin
            failures++;
            $display("[TB] FAIL busy_timing: m0 rvalid %0d m1 gnt %0d m1 rvalid %0d expected 3 5 7", rv0, g1, rv1);
        end
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL busy_data: m0 %h m1 %h expected deadbeef 12345678", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_back_to_back();
        idle(4);
        m0_we = 1'b1; m0_sel = 4'b0110; m0_addr = 32'h8000_0010; m0_wdata = 32'h1111_1111;
        m1_we = 1'b1; m1_sel = 4'b1001; m1_addr = 32'h8000_0014; m1_wdata = 32'h2222_2222;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({m0_gnt, m1_gnt, ram_we, ram_sel, ram_addr, ram_wdata} !==
                    {3'b101, 4'b0110, 11'd4, 32'h1111_1111}) begin
                    failures++;
                    $display("[TB] FAIL b2b_first: gnt0/gnt1/we=%b sel=%b addr=%0d wdata=%h expected 101 0110 4 11111111",
                             {m0_gnt, m1_gnt, ram_we}, ram_sel, ram_addr, ram_wdata);
                end
                m0_req = 1'b0;
            end
            if (n == 2) begin
                checks++;
                if ({m0_gnt, m1_gnt, ram_ce} !== 3'b000) begin
                    failures++;
                    $display("[TB] FAIL b2b_gap: gnt0/gnt1/ce=%b expected 000", {m0_gnt, m1_gnt, ram_ce});
                end
            end
            if (n == 3) begin
                checks++;
                if ({m0_gnt, m1_gnt, ram_we, ram_sel, ram_addr, ram_wdata} !==
                    {3'b011, 4'b1001, 11'd5, 32'h2222_2222}) begin
                    failures++;
                    $display("[TB] FAIL b2b_second: gnt0/gnt1/we=%b sel=%b addr=%0d wdata=%h expected 011 1001 5 22222222",
                             {m0_gnt, m1_gnt, ram_we}, ram_sel, ram_addr, ram_wdata);
                end
                m1_req = 1'b0;
            end
        end
    endtask

    initial begin
        $display("[TB] starting dram_arbiter bench");
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_last_word();
        test_reset_in_rwait();
        test_busy_request();
        test_back_to_back();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
